// File: rtl/instr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_pkg
// Description : Shared types and helpers for the RISC-V instruction packer.
//               It provides the format codes, the base opcode constants, the
//               decoded field-bundle struct, the packing function and the
//               drop-decision function.
//               Optional macro IMM_RANGE_CHECK_EN: when it is defined, bundles
//               whose immediate cannot be represented in the target format
//               are dropped. When it is undefined, immediates are truncated.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_pkg;

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4,
    FMT_R = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // The format field is kept as raw bits so that the illegal codes 6 and 7
  // can be carried through and then rejected.
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } bundle_t;

  function automatic logic [31:0] pack_instr(input bundle_t b);
    logic [31:0] w;
    w = '0;
    case (b.fmt)
      FMT_R: w = {b.funct7, b.rs2, b.rs1, b.funct3, b.rd, b.opcode};
      FMT_I: w = {b.imm[11:0], b.rs1, b.funct3, b.rd, b.opcode};
      FMT_S: w = {b.imm[11:5], b.rs2, b.rs1, b.funct3, b.imm[4:0], b.opcode};
      FMT_B: w = {b.imm[12], b.imm[10:5], b.rs2, b.rs1, b.funct3,
                  b.imm[4:1], b.imm[11], b.opcode};
      FMT_U: w = {b.imm[31:12], b.rd, b.opcode};
      FMT_J: w = {b.imm[20], b.imm[10:1], b.imm[11], b.imm[19:12],
                  b.rd, b.opcode};
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic drop_bundle(input bundle_t b);
    logic bad;
    bad = (b.fmt == 3'd6) || (b.fmt == 3'd7);
`ifdef IMM_RANGE_CHECK_EN
    // An immediate is representable when every bit above the top encoded bit
    // is a copy of that bit (all ones or all zeros).
    case (b.fmt)
      FMT_I, FMT_S:
        bad = !((&b.imm[31:11]) || !(|b.imm[31:11]));
      FMT_B:
        bad = !((&b.imm[31:12]) || !(|b.imm[31:12])) || b.imm[0];
      FMT_J:
        bad = !((&b.imm[31:20]) || !(|b.imm[31:20])) || b.imm[0];
      FMT_U:
        bad = |b.imm[11:0];
      default: ;
    endcase
`endif
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : instr_fifo
// Description : Synchronous FIFO for packed instruction words.
// Ports       : clk, rst_n (async active-low), clear_i (sync flush),
//               wr_en_i/wr_data_i, rd_en_i, rd_data_o (zero while empty),
//               full_o, empty_o (both derived from the registered count)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             w_wr, w_rd;

  assign full_o  = (count_q == C_FULL_CNT);
  assign empty_o = (count_q == '0);
  assign w_wr    = wr_en_i && !full_o;
  assign w_rd    = rd_en_i && !empty_o;
  // Gate the head so that a flushed or reset FIFO presents an all-zero word.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr && !clear_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule
`default_nettype wire

// File: rtl/instr_packer.sv
`default_nettype none
// ============================================================================
// Module      : instr_packer
// Description : Streaming RISC-V instruction encoder. It packs decoded field
//               bundles into 32-bit words, queues them in a FIFO and tags
//               each word with a word-aligned address.
//               Optional macro IMM_RANGE_CHECK_EN: it drops bundles whose
//               immediate does not fit the selected format.
// Ports       : clk, rst_n (async active-low), clear (sync flush)
//               in_valid/in_ready + in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
//               in_funct3, in_funct7, in_imm : field bundle input
//               out_valid/out_ready + out_instr, out_addr : word output
//               err_pulse, err_count : dropped-bundle flag and counter
// Revision    : 1.0 - initial release
// ============================================================================
module instr_packer
  import instr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_pulse,
  output logic [7:0]  err_count
);

  bundle_t     w_bundle;
  logic [31:0] w_pack;
  logic        w_drop;

  logic        s1_valid_q, s1_valid_d;
  logic        s1_drop_q, s1_drop_d;
  logic [31:0] s1_instr_q, s1_instr_d;
  logic [31:0] addr_q, addr_d;
  logic        err_pulse_q, err_pulse_d;
  logic [7:0]  err_count_q, err_count_d;

  logic        w_fifo_full, w_fifo_empty, w_fifo_wr, w_fifo_rd;
  logic        w_s1_advance, w_accept, w_out_hs;

  assign w_bundle = '{fmt: in_fmt, opcode: in_opcode, rd: in_rd, rs1: in_rs1,
                      rs2: in_rs2, funct3: in_funct3, funct7: in_funct7,
                      imm: in_imm};
  assign w_pack   = pack_instr(w_bundle);
  assign w_drop   = drop_bundle(w_bundle);

  // A doomed bundle leaves stage 1 without needing FIFO space. in_ready uses
  // only registered state, so no combinational path runs from out_ready.
  assign w_s1_advance = s1_valid_q && (s1_drop_q || !w_fifo_full);
  assign in_ready     = !s1_valid_q || w_s1_advance;
  assign w_accept     = in_valid && in_ready;
  assign w_fifo_wr    = s1_valid_q && !s1_drop_q && !w_fifo_full && !clear;
  assign w_out_hs     = out_valid && out_ready;
  assign w_fifo_rd    = w_out_hs && !clear;

  assign out_valid = !w_fifo_empty;
  assign out_addr  = addr_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_drop_d   = s1_drop_q;
    s1_instr_d  = s1_instr_q;
    addr_d      = addr_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    if (clear) begin
      s1_valid_d  = 1'b0;
      s1_drop_d   = 1'b0;
      s1_instr_d  = '0;
      addr_d      = BASE_ADDR;
      err_count_d = '0;
    end else begin
      if (w_accept) begin
        s1_valid_d = 1'b1;
        s1_drop_d  = w_drop;
        s1_instr_d = w_pack;
      end else if (w_s1_advance) begin
        s1_valid_d = 1'b0;
      end
      if (s1_valid_q && s1_drop_q) begin
        err_pulse_d = 1'b1;
        if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      end
      // Dropped bundles never reach the FIFO, so they consume no address.
      if (w_out_hs) addr_d = addr_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_drop_q   <= 1'b0;
      s1_instr_q  <= '0;
      addr_q      <= BASE_ADDR;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_drop_q   <= s1_drop_d;
      s1_instr_q  <= s1_instr_d;
      addr_q      <= addr_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear),
    .wr_en_i   (w_fifo_wr),
    .wr_data_i (s1_instr_q),
    .rd_en_i   (w_fifo_rd),
    .rd_data_o (out_instr),
    .full_o    (w_fifo_full),
    .empty_o   (w_fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_instr_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_packer
// Description : Directed bench for instr_packer. Expected words and
//               addresses are hand-computed. It follows IMM_RANGE_CHECK_EN
//               in the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr, out_addr;
  logic        err_pulse;
  logic [7:0]  err_count;

  int vecs = 0;
  int miscompares = 0;
  int acc_count = 0;
  logic [31:0] q_instr[$];
  logic [31:0] q_addr[$];
  logic [31:0] next_addr;

  instr_packer #(.BASE_ADDR(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge, so the values seen at the falling
  // edge are the ones that the next rising edge acts on.
  always @(negedge clk) begin
    if (rst_n && !clear && out_valid && out_ready) begin
      q_instr.push_back(out_instr);
      q_addr.push_back(out_addr);
    end
    if (rst_n && !clear && in_valid && in_ready) acc_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm);
    int n;
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      vecs++;
      miscompares++;
      $error("FAIL send_timeout: observed in_ready=0 expected 1 within 200 cycles");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_word(input string tag, input logic [31:0] ei,
                          input logic [31:0] ea);
    int n;
    n = 0;
    while (q_instr.size() == 0 && n < 200) begin
      tick();
      n++;
    end
    if (q_instr.size() == 0) begin
      vecs++;
      miscompares++;
      $error("FAIL %s_timeout: observed no word expected %h", tag, ei);
    end else begin
      chk({tag, "_instr"}, q_instr.pop_front(), ei);
      chk({tag, "_addr"}, q_addr.pop_front(), ea);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_err_pulse", 32'(err_pulse), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // addi x1,x0,5, including the 2-cycle latency
    send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    chk("lat_k", 32'(out_valid), 32'd0);
    tick();
    chk("lat_k1", 32'(out_valid), 32'd1);
    pop_word("addi", 32'h0050_0093, 32'h0);

    pulse_clear();
    chk("clr_addr", out_addr, 32'h0);

    // sw x2,-4(x1) then beq x0,x0,-8, back to back
    send(3'd1, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC);
    send(3'd2, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFF8);
    pop_word("sw", 32'hFE20_AE23, 32'h0);
    pop_word("beq", 32'hFE00_0CE3, 32'h4);

    // jal x1,2048 and lui x5,0x12345
    send(3'd4, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
    send(3'd3, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    pop_word("jal", 32'h0010_00EF, 32'h8);
    pop_word("lui", 32'h1234_52B7, 32'hC);

    // I-format immediate 2048: out of range only with the check enabled
    send(3'd0, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
`ifdef IMM_RANGE_CHECK_EN
    tick();
    chk("imm2048_pulse", 32'(err_pulse), 32'd1);
    chk("imm2048_count", 32'(err_count), 32'd1);
    tick();
    chk("imm2048_pulse_end", 32'(err_pulse), 32'd0);
    chk("imm2048_noword", 32'(q_instr.size()), 32'd0);
    next_addr = 32'h10;
`else
    pop_word("imm2048", 32'h8000_0093, 32'h10);
    next_addr = 32'h14;
`endif

    // An illegal format is dropped in every build
    send(3'd6, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    tick();
    chk("fmt6_pulse", 32'(err_pulse), 32'd1);
`ifdef IMM_RANGE_CHECK_EN
    chk("fmt6_count", 32'(err_count), 32'd2);
`else
    chk("fmt6_count", 32'(err_count), 32'd1);
`endif
    tick();
    chk("fmt6_pulse_end", 32'(err_pulse), 32'd0);

    // The next words keep the undisturbed address sequence
    send(3'd0, 7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    send(3'd5, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFF);
    pop_word("post_drop", 32'h0070_0113, next_addr);
    pop_word("add_r", 32'h0020_81B3, next_addr + 32'd4);

    // Backpressure: 6 pushes, 5 fit (4 in the FIFO + stage 1)
    pulse_clear();
    chk("clr_err_count", 32'(err_count), 32'd0);
    out_ready = 1'b0;
    acc_count = 0;
    for (int i = 0; i < 5; i++)
      send(3'd0, 7'b0010011, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    in_fmt = 3'd0; in_opcode = 7'b0010011; in_rd = 5'd6; in_rs1 = 5'd0;
    in_imm = 32'd5;
    in_valid = 1'b1;
    repeat (4) tick();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_accepted", 32'(acc_count), 32'd5);
    chk("full_head_instr", out_instr, 32'h0050_0093);
    chk("full_head_addr", out_addr, 32'h0);
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++)
      pop_word("bp", 32'h0050_0013 | (32'(i + 1) << 7), 32'(4 * i));

    // Reset with words pending
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(3'd0, 7'b0010011, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    repeat (3) tick();
    chk("pend_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_addr", out_addr, 32'h0);
    chk("mid_rst_instr", out_instr, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    send(3'd3, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    pop_word("after_rst", 32'h1234_52B7, 32'h0);
    repeat (5) tick();
    chk("no_stale", 32'(q_instr.size()), 32'd0);
    chk("idle_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_packer.md
# instr_packer

Streaming RISC-V instruction encoder: the inverse of the decode-side immediate generator. It accepts decoded instruction fields (format, opcode, registers, funct fields, 32-bit sign-extended immediate) over a valid/ready handshake, scatters the immediate into the I/S/B/U/J bit layouts, and emits packed 32-bit instruction words with word-aligned target addresses. It sits between the debug/boot loader and the instruction-memory write port, and is also used by the bench to produce decoder stimulus.

## Interface
- BASE_ADDR, 32'h0000_0000, address attached to the first emitted word after reset/clear
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous and active-low
- clear  input  1  synchronous flush: empties stage 1 and FIFO, reloads address to BASE_ADDR, clears err_count
- in_valid  input  1  field bundle valid
- in_ready  output  1  bundle accepted on in_valid && in_ready
- in_fmt  input  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=R; 6,7 illegal
- in_opcode  input  7  instr[6:0]
- in_rd, in_rs1, in_rs2  input  5 each  register indices
- in_funct3  input  3;  in_funct7  input  7 (R only)
- in_imm  input  32  sign-extended immediate, byte units (U: full value, low 12 bits zero)
- out_valid  output  1  FIFO head valid
- out_ready  input  1  consumer accepts head
- out_instr  output  32  packed word
- out_addr  output  32  address for out_instr
- err_pulse  output  1  one-cycle flag: bundle dropped
- err_count  output  8  saturating count of dropped bundles

## Operation
- Packing (fields not in a format are ignored):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Illegality (drop + err_pulse): fmt 6/7 always; range violations per Configuration.
- Stage 1 register holds one bundle; advances when FIFO not full, or unconditionally when the bundle is being dropped.
- in_ready = !s1_valid || s1_advance; depends only on registered state (no out_ready→in_ready path).
- Address counter: increments by 4 on each out handshake, wraps 32'hFFFF_FFFC→0. Dropped bundles consume no address.
- err_count saturates at 255.
- Reset/clear: in_ready=1, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_pulse=0, err_count=0. Reset mid-stream discards all pending words; clear has priority over same-cycle handshakes.

## Timing
- Accept at edge k → FIFO write at edge k+1 → out_valid high from edge k+1 (2-cycle latency, empty FIFO). err_pulse high for the cycle after edge k+1.
- Sustained throughput 1 word/cycle with out_ready held high.
- FIFO full: no write that cycle even if out_ready=1 (full is registered); stage 1 holds, in_ready=0.
- out_instr/out_addr stable while out_valid && !out_ready.
- Order strictly preserved.

## Configuration
- IMM_RANGE_CHECK_EN defined: drop when I/S imm[31:11] not uniform; B imm[31:12] not uniform or imm[0]=1; J imm[31:20] not uniform or imm[0]=1; U imm[11:0]≠0.
- Undefined: immediates truncated silently; only fmt 6/7 drops.

## Structure
- Package instr_pkg: format codes, base opcode constants, packed field-bundle struct.
- One sub-module: instr_fifo (sync FIFO, DEPTH, 64-bit word {addr, instr} or instr only with address computed at head).

## Test plan
- I addi x1,x0,5 (op 0010011, rd 1, f3 0, imm 5) → out_instr 0x00500093, out_addr 0x0.
- S sw x2,-4(x1) then B beq x0,x0,-8 → 0xFE20AE23 @0x0, 0xFE000CE3 @0x4.
- J jal x1,2048 and U lui x5,0x12345 → 0x001000EF, 0x123452B7.
- I imm=2048: with IMM_RANGE_CHECK_EN → err_pulse one cycle, err_count=1, no output, next word keeps address; without → 0x80000093.
- out_ready=0, push 6 bundles, DEPTH 4 → 5 accepted, in_ready low; release → addrs 0,4,8,12,16,20 in order.
- rst_n low with 3 words pending → out_valid=0 immediately, out_addr=BASE_ADDR; next word emitted at BASE_ADDR.
